// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480 timing, pixel and control types, colour-bar table.
// Shared by vga_scan_ctrl and vga_delay_line.
package vga_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Address outputs are 10 bits; counters get one extra bit so totals above 1024 fit.
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned CNT_W  = 11;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   // Per-pixel control word carried alongside the memory read latency.
   typedef struct packed {
      logic fs;   // first active pixel of the frame
      logic vs;   // vsync at output polarity
      logic hs;   // hsync at output polarity
      logic act;  // active video
   } scan_ctl_t;

   localparam int unsigned CTL_W = $bits(scan_ctl_t);

   // Colour-bar table, left to right.
   function automatic rgb24_t bar_colour(input logic [2:0] idx);
      rgb24_t c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;  // white
         3'd1:    c = 24'hFFFF00;  // yellow
         3'd2:    c = 24'h00FFFF;  // cyan
         3'd3:    c = 24'h00FF00;  // green
         3'd4:    c = 24'hFF00FF;  // magenta
         3'd5:    c = 24'hFF0000;  // red
         3'd6:    c = 24'h0000FF;  // blue
         3'd7:    c = 24'h000000;  // black
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline with stall enable and async reset.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int unsigned     WIDTH   = 1,
   parameter int unsigned     DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic bypass_unused;
         assign bypass_unused = ^{clk, rst, en_i};
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         // Shift the pipeline one stage per enabled cycle; hold when stalled.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  stage_q[i] <= RST_VAL;
               end
            end else if (en_i) begin
               stage_q[0] <= d_i;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign q_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: raster counters, registered pixel-memory addressing and
// sync/valid/colour outputs aligned to the memory read latency.
// Optional colour-bar generator: define VGA_SCAN_TESTPAT_EN.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned H_FP        = DEF_H_FP,
   parameter int unsigned H_SYNC      = DEF_H_SYNC,
   parameter int unsigned H_BP        = DEF_H_BP,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned V_FP        = DEF_V_FP,
   parameter int unsigned V_SYNC      = DEF_V_SYNC,
   parameter int unsigned V_BP        = DEF_V_BP,
   parameter bit          HS_POL      = 1'b0,
   parameter bit          VS_POL      = 1'b0,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned SCALE_SHIFT = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              test_en,
   output logic [ADDR_W-1:0] h_addr,
   output logic [ADDR_W-1:0] v_addr,
   output logic              rd_en,
   input  logic [23:0]       vga_data,
   output logic              hsync,
   output logic              vsync,
   output logic              valid,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SCAN_TESTPAT_EN
   // Pipeline word: {test_en, bar index, control}.
   localparam int unsigned PIPE_W = CTL_W + 4;
`else
   localparam int unsigned PIPE_W = CTL_W;
`endif

   localparam scan_ctl_t          CTL_RST  = '{fs: 1'b0, vs: ~VS_POL, hs: ~HS_POL, act: 1'b0};
   localparam logic [PIPE_W-1:0]  PIPE_RST = PIPE_W'(CTL_RST);

   logic [CNT_W-1:0]  h_q, v_q, h_d, v_d;
   logic [ADDR_W-1:0] h_scaled_s, v_scaled_s;
   logic [ADDR_W-1:0] h_addr_q, v_addr_q;
   logic              rd_en_q;
   scan_ctl_t         ctl_d;
   logic [PIPE_W-1:0] pipe_in_s, stage_q, pipe_out_s;
   scan_ctl_t         ctl_dly_s;
   logic              valid_q, hsync_q, vsync_q, fs_q;
   rgb24_t            rgb_d, rgb_q;

   // Next raster position: h wraps at end of line, v steps on that wrap.
   always_comb begin
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
         h_d = h_q + 11'd1;
         v_d = v_q;
      end
   end

   // Raster counters advance only while scanning is enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_q <= '0;
         v_q <= '0;
      end else if (en) begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Decode the current position into active/sync/frame-start control.
   always_comb begin
      ctl_d.act = (h_q < H_ACT_C) && (v_q < V_ACT_C);
      ctl_d.hs  = ((h_q >= H_SS) && (h_q < H_SE)) ? HS_POL : ~HS_POL;
      ctl_d.vs  = ((v_q >= V_SS) && (v_q < V_SE)) ? VS_POL : ~VS_POL;
      ctl_d.fs  = (h_q == '0) && (v_q == '0);
   end

   assign h_scaled_s = ADDR_W'(h_q >> SCALE_SHIFT);
   assign v_scaled_s = ADDR_W'(v_q >> SCALE_SHIFT);

`ifdef VGA_SCAN_TESTPAT_EN
   // Eight bars of equal width spanning the visible address range.
   localparam int unsigned BAR_SPAN = H_ACTIVE >> SCALE_SHIFT;
   logic [2:0] bar_s;

   // Bar index = number of bar boundaries at or left of this column.
   always_comb begin
      bar_s = 3'd0;
      for (int k = 1; k < 8; k++) begin
         bar_s = ({3'b000, h_scaled_s, 3'b000} >= 16'(k * BAR_SPAN)) ? 3'(k) : bar_s;
      end
   end

   assign pipe_in_s = {test_en, bar_s, ctl_d};
`else
   logic test_en_unused;
   assign test_en_unused = test_en;
   assign pipe_in_s      = ctl_d;
`endif

   // Address stage: memory address plus the control word for the same pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_addr_q <= '0;
         v_addr_q <= '0;
         rd_en_q  <= 1'b0;
         stage_q  <= PIPE_RST;
      end else if (en) begin
         h_addr_q <= ctl_d.act ? h_scaled_s : '0;
         v_addr_q <= ctl_d.act ? v_scaled_s : '0;
         rd_en_q  <= ctl_d.act;
         stage_q  <= pipe_in_s;
      end
   end

   vga_delay_line #(
      .WIDTH   (PIPE_W),
      .DEPTH   (RD_LAT),
      .RST_VAL (PIPE_RST)
   ) u_ctl_dly (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .d_i  (stage_q),
      .q_o  (pipe_out_s)
   );

   assign ctl_dly_s = scan_ctl_t'(pipe_out_s[CTL_W-1:0]);

   // Colour for the pixel whose memory data is arriving now; black when blanked.
   always_comb begin
      if (!ctl_dly_s.act) begin
         rgb_d = '0;
`ifdef VGA_SCAN_TESTPAT_EN
      end else if (pipe_out_s[PIPE_W-1]) begin
         rgb_d = bar_colour(pipe_out_s[CTL_W+2:CTL_W]);
`endif
      end else begin
         rgb_d = vga_data;
      end
   end

   // Output registers: one cycle after the data arrives, RD_LAT+1 after the address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         fs_q    <= 1'b0;
         rgb_q   <= '0;
      end else if (en) begin
         valid_q <= ctl_dly_s.act;
         hsync_q <= ctl_dly_s.hs;
         vsync_q <= ctl_dly_s.vs;
         fs_q    <= ctl_dly_s.fs;
         rgb_q   <= rgb_d;
      end
   end

   assign h_addr      = h_addr_q;
   assign v_addr      = v_addr_q;
   assign rd_en       = rd_en_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign valid       = valid_q;
   assign frame_start = fs_q;
   assign vga_r       = rgb_q.r;
   assign vga_g       = rgb_q.g;
   assign vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed vector table plus stall, mid-frame reset and
// frame-timing sequences on a reduced 16x8 raster (24x13 total).
// Colour-bar checks are compiled when VGA_SCAN_TESTPAT_EN is defined.
`timescale 1ns/1ps
module tb_vga_scan_ctrl;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;   // 24
   localparam int VT = VA + VF + VS + VB;   // 13
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst, en, test_en;
   logic [9:0]  h_addr, v_addr;
   logic        rd_en;
   logic [23:0] vga_data;
   logic        hsync, vsync, valid, frame_start;
   logic [7:0]  vga_r, vga_g, vga_b;

   // Second instance: pixel replication by 2, single-cycle memory.
   logic [9:0]  sh_addr, sv_addr;
   logic        s_rd_en, s_hsync, s_vsync, s_valid, s_fs;
   logic [7:0]  s_r, s_g, s_b;
   logic [23:0] s_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(LAT), .SCALE_SHIFT(0)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .test_en(test_en),
      .h_addr(h_addr), .v_addr(v_addr), .rd_en(rd_en), .vga_data(vga_data),
      .hsync(hsync), .vsync(vsync), .valid(valid),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
   );

   vga_scan_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1), .SCALE_SHIFT(1)
   ) dut_s (
      .clk(clk), .rst(rst), .en(en), .test_en(test_en),
      .h_addr(sh_addr), .v_addr(sv_addr), .rd_en(s_rd_en), .vga_data(s_data),
      .hsync(s_hsync), .vsync(s_vsync), .valid(s_valid),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .frame_start(s_fs)
   );

   assign s_data = 24'h000000;

   // Memory model: returns {4'hA, h_addr, v_addr} LAT enabled cycles after the address.
   logic [19:0] mem_pipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) mem_pipe[i] <= 20'h00000;
      end else if (en) begin
         mem_pipe[0] <= {h_addr, v_addr};
         for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
      end
   end
   assign vga_data = {4'hA, mem_pipe[LAT-1]};

   typedef struct {
      int         n;
      logic [9:0] ha, va;
      logic       rd;
      logic [9:0] sha, sva;
      logic       hs, vs, vl, fs;
      logic [23:0] rgb;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: {fs, vsync, hsync, valid, rgb} after n enabled edges from reset.
   function automatic logic [27:0] exp_out(input int n);
      int q, h, v;
      logic act;
      q = n - LAT - 2;
      if (q < 0) return {1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};
      h = q % HT;
      v = (q / HT) % VT;
      act = (h < HA) && (v < VA);
      return {act && (h == 0) && (v == 0),
              !((v >= VA + VF) && (v < VA + VF + VS)),
              !((h >= HA + HF) && (h < HA + HF + HS)),
              act,
              act ? {4'hA, 10'(h), 10'(v)} : 24'h000000};
   endfunction

   // Reference: {rd_en, h_addr, v_addr} after n enabled edges from reset.
   function automatic logic [20:0] exp_addr(input int n);
      int p, h, v;
      p = n - 1;
      if (p < 0) return 21'h0;
      h = p % HT;
      v = (p / HT) % VT;
      if ((h < HA) && (v < VA)) return {1'b1, 10'(h), 10'(v)};
      return 21'h0;
   endfunction

   function automatic logic [27:0] act_out();
      return {frame_start, vsync, hsync, valid, vga_r, vga_g, vga_b};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
   endtask

   initial begin
      int idx;
      int miss;
      int found;
      int hs_low, vs_low, vl_cnt, fs_cnt;
      int hs_f1, hs_f2, vs_f1, vs_f2;
      logic prev_hs, prev_vs;

      rst = 1'b1;
      en = 1'b0;
      test_en = 1'b0;

      //               n    ha     va     rd    sha    sva   hs    vs    vl    fs    rgb
      tbl.push_back('{  0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{  1, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{  4, 10'd3, 10'd0, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{  5, 10'd4, 10'd0, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00000});
      tbl.push_back('{  6, 10'd5, 10'd0, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA00400});
      tbl.push_back('{ 16, 10'd15,10'd0, 1'b1, 10'd7, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA02C00});
      tbl.push_back('{ 17, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA03000});
      tbl.push_back('{ 20, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA03C00});
      tbl.push_back('{ 21, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{ 23, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{ 25, 10'd0, 10'd1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{ 26, 10'd1, 10'd1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{ 29, 10'd4, 10'd1, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA00001});
      tbl.push_back('{ 49, 10'd0, 10'd2, 1'b1, 10'd0, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{ 73, 10'd0, 10'd3, 1'b1, 10'd0, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{174, 10'd5, 10'd7, 1'b1, 10'd2, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA00407});
      tbl.push_back('{178, 10'd9, 10'd7, 1'b1, 10'd4, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA01407});
      tbl.push_back('{193, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{197, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{217, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{221, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{269, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{313, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000});
      tbl.push_back('{317, 10'd4, 10'd0, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 24'hA00000});

      // Table pass: continuous scan from reset, sampled on falling edges.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      idx = 0;
      for (int n = 0; n <= 317; n++) begin
         if (n > 0) @(negedge clk);
         while ((idx < tbl.size()) && (tbl[idx].n == n)) begin
            chk($sformatf("vec%0d_addr", n),
                64'({rd_en, h_addr, v_addr, sh_addr, sv_addr}),
                64'({tbl[idx].rd, tbl[idx].ha, tbl[idx].va, tbl[idx].sha, tbl[idx].sva}));
            chk($sformatf("vec%0d_out", n),
                64'({frame_start, vsync, hsync, valid, vga_r, vga_g, vga_b}),
                64'({tbl[idx].fs, tbl[idx].vs, tbl[idx].hs, tbl[idx].vl, tbl[idx].rgb}));
            idx++;
         end
      end

      // Frame timing: one full frame of counts, then sync periods from falling edges.
      hs_low = 0; vs_low = 0; vl_cnt = 0; fs_cnt = 0;
      hs_f1 = -1; hs_f2 = -1; vs_f1 = -1; vs_f2 = -1;
      prev_hs = hsync;
      prev_vs = vsync;
      for (int n = 318; n < 318 + 700; n++) begin
         @(negedge clk);
         if (n < 318 + HT * VT) begin
            hs_low += (hsync == 1'b0) ? 1 : 0;
            vs_low += (vsync == 1'b0) ? 1 : 0;
            vl_cnt += (valid == 1'b1) ? 1 : 0;
            fs_cnt += (frame_start == 1'b1) ? 1 : 0;
         end
         if (prev_hs && !hsync) begin
            if (hs_f1 < 0) hs_f1 = n;
            else if (hs_f2 < 0) hs_f2 = n;
         end
         if (prev_vs && !vsync) begin
            if (vs_f1 < 0) vs_f1 = n;
            else if (vs_f2 < 0) vs_f2 = n;
         end
         prev_hs = hsync;
         prev_vs = vsync;
      end
      chk("hsync_low_per_frame", 64'(hs_low), 64'(HS * VT));
      chk("vsync_low_per_frame", 64'(vs_low), 64'(VS * HT));
      chk("valid_per_frame",     64'(vl_cnt), 64'(HA * VA));
      chk("fs_per_frame",        64'(fs_cnt), 64'd1);
      chk("hsync_period", 64'((hs_f2 < 0) ? 0 : hs_f2 - hs_f1), 64'(HT));
      chk("vsync_period", 64'((vs_f2 < 0) ? 0 : vs_f2 - vs_f1), 64'(HT * VT));

      // Stall of 37 cycles mid-line: frozen outputs, then the unstalled stream.
      do_reset();
      miss = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if ((act_out() !== exp_out(k)) || ({rd_en, h_addr, v_addr} !== exp_addr(k))) miss++;
      end
      chk("prestall_stream", 64'(miss), 64'd0);
      en = 1'b0;
      miss = 0;
      for (int c = 0; c < 37; c++) begin
         @(negedge clk);
         if ((act_out() !== exp_out(10)) || ({rd_en, h_addr, v_addr} !== exp_addr(10))) miss++;
      end
      chk("stall_frozen", 64'(miss), 64'd0);
      en = 1'b1;
      miss = 0;
      for (int k = 11; k <= 83; k++) begin
         @(negedge clk);
         if ((act_out() !== exp_out(k)) || ({rd_en, h_addr, v_addr} !== exp_addr(k))) miss++;
      end
      chk("stall_resume_stream", 64'(miss), 64'd0);
      chk("pre_reset_valid", 64'(valid), 64'd1);

      // Asynchronous reset mid-frame, observed before the next rising edge.
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out",  64'(act_out()), 64'({1'b0, 1'b1, 1'b1, 1'b0, 24'h000000}));
      chk("async_rst_addr", 64'({rd_en, h_addr, v_addr, sh_addr, sv_addr}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      found = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            found = c;
            break;
         end
      end
      chk("fs_after_reset", 64'(found), 64'(LAT + 2));

`ifdef VGA_SCAN_TESTPAT_EN
      // Colour bars: bars are 2 pixels wide on this 16-pixel line.
      test_en = 1'b1;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 5)  chk("bar_px0",  64'({valid, vga_r, vga_g, vga_b}), 64'({1'b1, 24'hFFFFFF}));
         if (k == 7)  chk("bar_px2",  64'({valid, vga_r, vga_g, vga_b}), 64'({1'b1, 24'hFFFF00}));
         if (k == 20) chk("bar_px15", 64'({valid, vga_r, vga_g, vga_b}), 64'({1'b1, 24'h000000}));
      end
      test_en = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
